// File: rtl/polsub_ctrl_pkg.sv
// rtl/polsub_ctrl_pkg.sv - shared constants and types for the polynomial subtraction engine
//
// Contents:
//   KYBER_Q     Kyber modulus, 13 bits so it can be added to a signed difference
//   COEF_W      coefficient width
//   N_DEF       default number of coefficients per polynomial
//   ADDR_W_DEF  default RAM address width
//   state_e     sequencer states
package polsub_ctrl_pkg;

    localparam logic [12:0] KYBER_Q    = 13'd3329;
    localparam int          COEF_W     = 12;
    localparam int          N_DEF      = 256;
    localparam int          ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/polsub_ctrl_modsub.sv
// rtl/polsub_ctrl_modsub.sv - combinational (x - y) mod 3329 for canonical coefficients
//
// Ports:
//   x_i  minuend, canonical 0..3328
//   y_i  subtrahend, canonical 0..3328
//   r_o  (x_i - y_i) mod 3329, canonical 0..3328
module polsub_ctrl_modsub
    import polsub_ctrl_pkg::*;
(
    input  logic [COEF_W-1:0] x_i,
    input  logic [COEF_W-1:0] y_i,
    output logic [COEF_W-1:0] r_o
);

    logic [COEF_W:0] diff;
    logic [COEF_W:0] wrapped;

    // One extra bit holds the sign of the difference; with canonical inputs a
    // single conditional add of q is enough to land back in 0..q-1.
    assign diff    = {1'b0, x_i} - {1'b0, y_i};
    assign wrapped = diff + KYBER_Q;
    assign r_o     = diff[COEF_W] ? wrapped[COEF_W-1:0] : diff[COEF_W-1:0];

endmodule

// File: rtl/polsub_ctrl.sv
// rtl/polsub_ctrl.sv - sequencer for C[k] = (A[k] - B[k]) mod 3329 over dual-RAM polynomials
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   start    begin one pass (sampled only in IDLE)
//   swap     latched at start: 0 -> C = A - B, 1 -> C = B - A
//   busy     high whenever the sequencer is not IDLE
//   done     one-cycle pulse at the end of a pass
//   rd_en    read enable to both A and B RAMs
//   rd_addr  shared A/B read address
//   a_dout   A RAM read data, valid RD_LAT cycles after rd_en
//   b_dout   B RAM read data, same timing as a_dout
//   wr_en    C RAM write enable
//   wr_addr  C RAM write address
//   wr_data  result coefficient, canonical 0..3328
module polsub_ctrl
    import polsub_ctrl_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              swap,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [COEF_W-1:0] a_dout,
    input  logic [COEF_W-1:0] b_dout,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [COEF_W-1:0] wr_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N - 1);
    // DRAIN lasts RD_LAT+1 cycles: the last read's data returns after RD_LAT
    // cycles and needs one more cycle to reach the output register.
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        drain_q, drain_d;
    logic              swap_q, swap_d;

    // Tracks each outstanding read so the write lines up with its data.
    logic [RD_LAT-1:0]             vld_q;
    logic [RD_LAT-1:0][ADDR_W-1:0] addr_q;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [COEF_W-1:0] wr_data_q;

    logic [COEF_W-1:0] op_x;
    logic [COEF_W-1:0] op_y;
    logic [COEF_W-1:0] mod_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drain_q <= '0;
            swap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            swap_q  <= swap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        swap_d  = swap_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    swap_d  = swap;
                end
            end
            RUN: begin
                // Counter holds at the last address so it never exceeds N-1.
                if (cnt_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_en   = (state_q == RUN);
    assign rd_addr = cnt_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            addr_q <= '0;
        end else begin
            vld_q[0]  <= rd_en;
            addr_q[0] <= cnt_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign op_x = swap_q ? b_dout : a_dout;
    assign op_y = swap_q ? a_dout : b_dout;

    polsub_ctrl_modsub u_modsub (
        .x_i (op_x),
        .y_i (op_y),
        .r_o (mod_r)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= vld_q[RD_LAT-1];
            if (vld_q[RD_LAT-1]) begin
                wr_addr_q <= addr_q[RD_LAT-1];
                wr_data_q <= mod_r;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_polsub_ctrl.sv
// tb/tb_polsub_ctrl.sv - directed self-checking bench for polsub_ctrl at RD_LAT 1 and 3
module tb_polsub_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        swap;

    logic        busy1, done1, rd_en1, wr_en1;
    logic [7:0]  rd_addr1, wr_addr1;
    logic [11:0] a1, b1, wr_data1;

    logic        busy3, done3, rd_en3, wr_en3;
    logic [7:0]  rd_addr3, wr_addr3;
    logic [11:0] wr_data3;
    logic [2:0][11:0] pa3, pb3;

    logic [11:0] mem_a [256];
    logic [11:0] mem_b [256];
    logic [11:0] exp_c [256];
    logic [11:0] c1    [256];
    logic [11:0] c3    [256];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int t0;
    bit timed_out;
    int saved;

    int wcnt1, first_wr1, last_wr1, done_cnt1, done_cyc1, busy_cnt1, busy_first1, overlap1, order_err1, rd_cnt1;
    int wcnt3, first_wr3, done_cnt3, done_cyc3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    polsub_ctrl #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .swap(swap),
        .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .a_dout(a1), .b_dout(b1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    polsub_ctrl #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start), .swap(swap),
        .busy(busy3), .done(done3), .rd_en(rd_en3), .rd_addr(rd_addr3),
        .a_dout(pa3[2]), .b_dout(pb3[2]),
        .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3)
    );

    // RAM models: one-cycle registered read, and a three-stage read pipeline.
    always @(posedge clk) begin
        if (rd_en1) begin
            a1 <= mem_a[rd_addr1];
            b1 <= mem_b[rd_addr1];
        end
        pa3 <= {pa3[1:0], mem_a[rd_addr3]};
        pb3 <= {pb3[1:0], mem_b[rd_addr3]};
    end

    always @(negedge clk) begin
        if (wr_en1) begin
            c1[wr_addr1] = wr_data1;
            if (wcnt1 == 0) first_wr1 = cyc;
            last_wr1 = cyc;
            if (wr_addr1 != 8'(wcnt1)) order_err1++;
            wcnt1++;
        end
        if (rd_en1) rd_cnt1++;
        if (done1) begin
            done_cnt1++;
            done_cyc1 = cyc;
        end
        if (busy1) begin
            if (busy_cnt1 == 0) busy_first1 = cyc;
            busy_cnt1++;
        end
        if (done1 && wr_en1) overlap1++;
        if (wr_en3) begin
            c3[wr_addr3] = wr_data3;
            if (wcnt3 == 0) first_wr3 = cyc;
            wcnt3++;
        end
        if (done3) begin
            done_cnt3++;
            done_cyc3 = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        wcnt1 = 0; first_wr1 = -1; last_wr1 = -1; done_cnt1 = 0; done_cyc1 = -1;
        busy_cnt1 = 0; busy_first1 = -1; overlap1 = 0; order_err1 = 0; rd_cnt1 = 0;
        wcnt3 = 0; first_wr3 = -1; done_cnt3 = 0; done_cyc3 = -1;
        for (int k = 0; k < 256; k++) begin
            c1[k] = 12'hfff;
            c3[k] = 12'hfff;
        end
    endtask

    function automatic int mem_errs(input bit lat3);
        int e = 0;
        for (int k = 0; k < 256; k++) begin
            if (lat3 ? (c3[k] !== exp_c[k]) : (c1[k] !== exp_c[k])) e++;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start_pass(input logic sw);
        tick();
        clear_stats();
        start = 1'b1;
        swap  = sw;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!(done_cnt1 > 0 && done_cnt3 > 0) && n < lim) begin
            tick();
            n++;
        end
        timed_out = (n >= lim);
        repeat (3) tick();
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_dut1"}, {busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1}, 0);
        chk({tag, "_dut3"}, {busy3, done3, rd_en3, wr_en3, rd_addr3, wr_addr3, wr_data3}, 0);
    endtask

    initial begin
        // Reset with random control inputs: every output must read zero.
        reset_n = 1'b0;
        start   = 1'b0;
        swap    = 1'b0;
        clear_stats();
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 12'(k);
            mem_b[k] = 12'd0;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'($urandom);
            swap  = 1'($urandom);
        end
        outputs_zero("reset_outputs");
        start = 1'b0;
        swap  = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_stats();
        repeat (10) tick();
        chk("idle_rd_cnt", rd_cnt1, 0);
        chk("idle_wr_cnt", wcnt1 + wcnt3, 0);
        chk("idle_busy", busy_cnt1, 0);

        // Basic pass: A[k]=k, B[k]=0 -> C[k]=k.
        for (int k = 0; k < 256; k++) exp_c[k] = 12'(k);
        start_pass(1'b0);
        wait_done(600);
        chk("basic_timeout", timed_out, 0);
        chk("basic_wcnt", wcnt1, 256);
        chk("basic_rd_cnt", rd_cnt1, 256);
        chk("basic_first_wr", first_wr1, t0 + 3);
        chk("basic_last_wr", last_wr1, t0 + 258);
        chk("basic_order", order_err1, 0);
        chk("basic_done_cyc", done_cyc1, t0 + 259);
        chk("basic_done_cnt", done_cnt1, 1);
        chk("basic_busy_first", busy_first1, t0 + 1);
        chk("basic_busy_cnt", busy_cnt1, 259);
        chk("basic_overlap", overlap1, 0);
        chk("basic_data", mem_errs(1'b0), 0);
        chk("lat3_wcnt", wcnt3, 256);
        chk("lat3_first_wr", first_wr3, t0 + 5);
        chk("lat3_done_cyc", done_cyc3, t0 + 261);
        chk("lat3_done_cnt", done_cnt3, 1);
        chk("lat3_data", mem_errs(1'b1), 0);

        // Wrap and boundary operand pairs, cycling over the address space.
        for (int k = 0; k < 256; k++) begin
            case (k % 4)
                0: begin mem_a[k] = 12'd0;    mem_b[k] = 12'd1;    exp_c[k] = 12'd3328; end
                1: begin mem_a[k] = 12'd0;    mem_b[k] = 12'd3328; exp_c[k] = 12'd1;    end
                2: begin mem_a[k] = 12'd3328; mem_b[k] = 12'd3328; exp_c[k] = 12'd0;    end
                default: begin mem_a[k] = 12'd3328; mem_b[k] = 12'd0; exp_c[k] = 12'd3328; end
            endcase
        end
        start_pass(1'b0);
        wait_done(600);
        chk("bound_timeout", timed_out, 0);
        chk("bound_wcnt", wcnt1, 256);
        chk("bound_data", mem_errs(1'b0), 0);
        chk("bound_data_lat3", mem_errs(1'b1), 0);

        // swap=1 with A=5, B=3 -> 3327; swap input toggled mid-pass is ignored.
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 12'd5;
            mem_b[k] = 12'd3;
            exp_c[k] = 12'd3327;
        end
        start_pass(1'b1);
        wait_cyc(t0 + 100);
        swap = 1'b0;
        wait_done(600);
        chk("swap_timeout", timed_out, 0);
        chk("swap_wcnt", wcnt1, 256);
        chk("swap_data", mem_errs(1'b0), 0);
        chk("swap_data_lat3", mem_errs(1'b1), 0);

        // Start pulsed while busy is ignored.
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 12'(k);
            mem_b[k] = 12'd0;
            exp_c[k] = 12'(k);
        end
        start_pass(1'b0);
        wait_cyc(t0 + 50);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(600);
        repeat (300) tick();
        chk("restart_timeout", timed_out, 0);
        chk("restart_wcnt", wcnt1, 256);
        chk("restart_done_cnt", done_cnt1, 1);
        chk("restart_done_cyc", done_cyc1, t0 + 259);
        chk("restart_data", mem_errs(1'b0), 0);

        // Reset mid-pass: outputs drop at once and no further writes occur.
        start_pass(1'b0);
        wait_cyc(t0 + 100);
        reset_n = 1'b0;
        #1;
        outputs_zero("midreset_outputs");
        chk("midreset_wcnt", wcnt1, 97);
        chk("midreset_wcnt_lat3", wcnt3, 95);
        saved = wcnt1;
        repeat (5) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("midreset_no_writes", wcnt1, saved);
        chk("midreset_idle", busy1, 0);
        start_pass(1'b0);
        wait_done(600);
        chk("postreset_timeout", timed_out, 0);
        chk("postreset_wcnt", wcnt1, 256);
        chk("postreset_done_cyc", done_cyc1, t0 + 259);
        chk("postreset_data", mem_errs(1'b0), 0);

        // start held high: back-to-back passes with one IDLE cycle between.
        tick();
        clear_stats();
        start = 1'b1;
        t0    = cyc;
        wait_cyc(t0 + 265);
        start = 1'b0;
        wait_cyc(t0 + 540);
        chk("held_done_cnt", done_cnt1, 2);
        chk("held_done_cyc", done_cyc1, t0 + 519);
        chk("held_wcnt", wcnt1, 512);
        chk("held_busy_cnt", busy_cnt1, 518);
        chk("held_overlap", overlap1, 0);
        chk("held_order", order_err1, 0);
        chk("held_end_idle", busy1 | busy3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
